// File: rtl/sauria_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sauria_pkg
// Purpose  : Shared types, constants and helpers for SAURIA datapath FIFOs.
//            fifo_mode_t selects the read mode of sauria_param_fifo.
//            fifo_cnt_w() gives the occupancy/threshold width for a depth.
//            FIFO_POSITIONS_* are the per-path depth sources.
// Revision : 1.0 - initial parametrised FIFO support
// ============================================================================
package sauria_pkg;

  typedef enum logic {
    FIFO_REG  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_t;

  // Per-path buffering depths used when instantiating sauria_param_fifo.
  localparam int FIFO_POSITIONS_WEIGHT = 4;
  localparam int FIFO_POSITIONS_IFMAP  = 4;
  localparam int FIFO_POSITIONS_PSUM   = 3;

  // The count must represent 0..depth inclusive, hence depth+1 values.
  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sauria_fifo_ptr.sv
`default_nettype none
// ============================================================================
// Module   : sauria_fifo_ptr
// Purpose  : FIFO pointer that wraps at DEPTH-1 (works for any DEPTH >= 2,
//            including non-power-of-2 depths).
// Ports    : i_clk  - clock
//            i_rstn - asynchronous active-low reset (pointer -> 0)
//            i_clr  - synchronous clear (pointer -> 0), priority over i_inc
//            i_inc  - advance pointer by one
//            o_ptr  - current pointer value
// Revision : 1.0 - initial release
// ============================================================================
module sauria_fifo_ptr #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [PTR_W-1:0] o_ptr
);

  localparam logic [PTR_W-1:0] c_LAST = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] c_ONE  = PTR_W'(1);

  logic [PTR_W-1:0] r_ptr;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_ptr <= '0;
    end else if (i_clr) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= (r_ptr == c_LAST) ? '0 : r_ptr + c_ONE;
    end
  end

  assign o_ptr = r_ptr;

endmodule
`default_nettype wire

// File: rtl/sauria_param_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sauria_param_fifo
// Purpose  : Parametrised synchronous FIFO for SAURIA datapath buffering,
//            with registered or first-word-fall-through read, almost-full
//            threshold, synchronous flush, occupancy count and sticky
//            overflow/underflow flags.
// Ports    : i_clk, i_rstn        - clock, async active-low reset
//            i_flush              - synchronous empty (priority over push/pop)
//            i_clr_err            - clear sticky error flags
//            i_push, i_data       - write request and data
//            i_pop, o_data        - read request and data
//            o_full, o_empty      - status
//            o_count              - occupancy 0..DEPTH
//            i_afull_th, o_afull  - almost-full threshold and flag
//            o_overflow           - sticky: push rejected while full
//            o_underflow          - sticky: pop rejected while empty
// Revision : 1.0 - initial release
// ============================================================================
module sauria_param_fifo
  import sauria_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4,
  parameter int FWFT  = 0,
  parameter int CNT_W = fifo_cnt_w(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_flush,
  input  logic             i_clr_err,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count,
  input  logic [CNT_W-1:0] i_afull_th,
  output logic             o_afull,
  output logic             o_overflow,
  output logic             o_underflow
);

  localparam int               c_PTR_W   = $clog2(DEPTH);
  localparam fifo_mode_t       c_MODE    = (FWFT != 0) ? FIFO_FWFT : FIFO_REG;
  localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   w_count_nxt;
  logic               r_overflow;
  logic               r_underflow;
  logic [c_PTR_W-1:0] w_wr_ptr;
  logic [c_PTR_W-1:0] w_rd_ptr;
  logic               w_full;
  logic               w_empty;
  logic               w_pop_ok;
  logic               w_push_ok;
  logic               w_push_rej;
  logic               w_pop_rej;

  assign w_full  = (r_count == c_CNT_MAX);
  assign w_empty = (r_count == '0);

  // Flush masks both requests, so neither transfers nor raises an error.
  assign w_pop_ok   = i_pop  & ~w_empty & ~i_flush;
  assign w_push_ok  = i_push & (~w_full | w_pop_ok) & ~i_flush;
  assign w_push_rej = i_push & ~i_flush & ~w_push_ok;
  assign w_pop_rej  = i_pop  & ~i_flush & w_empty;

  sauria_fifo_ptr #(.DEPTH(DEPTH), .PTR_W(c_PTR_W)) u_wr_ptr (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_clr  (i_flush),
    .i_inc  (w_push_ok),
    .o_ptr  (w_wr_ptr)
  );

  sauria_fifo_ptr #(.DEPTH(DEPTH), .PTR_W(c_PTR_W)) u_rd_ptr (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_clr  (i_flush),
    .i_inc  (w_pop_ok),
    .o_ptr  (w_rd_ptr)
  );

  always_comb begin
    w_count_nxt = r_count;
    if (i_flush) begin
      w_count_nxt = '0;
    end else begin
      case ({w_push_ok, w_pop_ok})
        2'b10:   w_count_nxt = r_count + c_CNT_ONE;
        2'b01:   w_count_nxt = r_count - c_CNT_ONE;
        default: w_count_nxt = r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      // A new error in the same cycle as a clear keeps the flag set.
      if (w_push_rej)     r_overflow  <= 1'b1;
      else if (i_clr_err) r_overflow  <= 1'b0;
      if (w_pop_rej)      r_underflow <= 1'b1;
      else if (i_clr_err) r_underflow <= 1'b0;
    end
  end

  // Storage is not reset; validity is tracked by the pointers and count.
  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[w_wr_ptr] <= i_data;
  end

  generate
    if (c_MODE == FIFO_FWFT) begin : g_fwft
      // Head shown combinationally; forced to zero while nothing is valid so
      // the output is deterministic out of reset.
      assign o_data = w_empty ? '0 : r_mem[w_rd_ptr];
    end else begin : g_reg
      logic [WIDTH-1:0] r_dout;
      always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn)       r_dout <= '0;
        else if (w_pop_ok) r_dout <= r_mem[w_rd_ptr];
      end
      assign o_data = r_dout;
    end
  endgenerate

  assign o_full      = w_full;
  assign o_empty     = w_empty;
  assign o_count     = r_count;
  // Threshold 0 is always met and any threshold above DEPTH never is, since
  // the count spans exactly 0..DEPTH; a plain compare covers both cases.
  assign o_afull     = (r_count >= i_afull_th);
  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;

`ifndef SYNTHESIS
  int w_ptr_diff;
  always_comb begin
    w_ptr_diff = int'(w_wr_ptr) - int'(w_rd_ptr);
    if (w_ptr_diff < 0) w_ptr_diff = w_ptr_diff + DEPTH;
  end

  a_count_matches_ptrs : assert property (@(posedge i_clk) disable iff (!i_rstn)
    (w_full ? (w_wr_ptr == w_rd_ptr) : (int'(r_count) == w_ptr_diff)));
`endif

endmodule
`default_nettype wire

// File: doc/sauria_param_fifo.md
Name: sauria_param_fifo

Overview:
- Parametrised synchronous FIFO for SAURIA datapath buffering: weight fetcher, IFmap feeder and psum drain paths.
- Replaces the fixed-position feeder FIFOs with one block configurable in data width, depth (including non-power-of-2), and read mode (registered or first-word-fall-through).
- Adds a programmable almost-full threshold, synchronous flush, occupancy count and sticky overflow/underflow flags that the control FSMs use for back-pressure and debug.

Parameters:
- WIDTH, 128, data width in bits (e.g. IB_W*X for the weight path).
- DEPTH, 4, number of entries; any value >= 2.
- FWFT, 0, read mode: 0 = registered output, 1 = first-word-fall-through.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count and threshold (derived; not overridden).

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  asynchronous active-low reset
- i_flush  in  1  synchronous flush: empties FIFO
- i_clr_err  in  1  clears sticky error flags
- i_push  in  1  write request
- i_data  in  WIDTH  write data
- i_pop  in  1  read request
- o_data  out  WIDTH  read data
- o_full  out  1  no free entry
- o_empty  out  1  no valid entry
- o_count  out  CNT_W  current occupancy, 0..DEPTH
- i_afull_th  in  CNT_W  almost-full threshold
- o_afull  out  1  o_count >= i_afull_th
- o_overflow  out  1  sticky: push rejected while full
- o_underflow  out  1  sticky: pop rejected while empty

Behaviour:
- Reset (i_rstn low, async): pointers = 0, count = 0, o_empty = 1, o_full = 0, o_data = 0, o_overflow = o_underflow = 0. Memory contents are not reset.
- Pointers wrap by explicit compare to DEPTH-1, not by modulo 2^n.
- Accepted push = i_push & (!full | accepted pop). Accepted pop = i_pop & !empty.
- Full with push and pop in the same cycle: both accepted; count unchanged.
- Empty with push and pop in the same cycle: push accepted; pop rejected and o_underflow set. This applies in both modes; there is no bypass of an empty FIFO.
- Rejected push: data dropped, o_overflow set. Rejected pop: o_underflow set. State is otherwise unchanged.
- o_count, o_full, o_empty and o_afull are registered-state-derived; all update on the cycle after the causing edge.
- o_afull threshold rules: i_afull_th = 0 forces o_afull = 1. i_afull_th > DEPTH forces o_afull = 0.
- FWFT = 1: o_data = mem[rd_ptr] combinationally; valid while !o_empty. Zero-latency read: data is consumed at the pop edge. After push into an empty FIFO, data is visible on the next cycle.
- FWFT = 0: on an accepted pop, o_data <= mem[rd_ptr] at that edge; data is valid one cycle after the pop. o_data holds its value until the next accepted pop.
- i_flush (priority over push/pop): pointers and count reset next edge; push/pop in that cycle are ignored and do not set error flags. o_data is not cleared. Error flags are unaffected.
- i_clr_err clears both sticky flags next edge. If a new error occurs in the same cycle, set wins.
- Reset asserted mid-operation discards all contents; no partial state survives.
- Invariant for assertions: o_count == (wr_ptr - rd_ptr) mod DEPTH, qualified by a full bit.

Decomposition:
- sauria_pkg gains a fifo_mode_t enum (FIFO_REG, FIFO_FWFT) and a function fifo_cnt_w(depth) returning $clog2(depth+1). The FIFO_POSITIONS constants remain there as DEPTH sources.
- One natural sub-module: sauria_fifo_ptr. It is a parametrised wrap-at-DEPTH-1 pointer with increment enable and sync clear, instantiated twice (rd and wr).
- Storage is an inferred register array; no SRAM macro.

Test Plan:
- DEPTH=4, FWFT=0: push 0xA,0xB,0xC,0xD -> o_full=1, o_count=4. Four pops -> o_data sequence A,B,C,D, each one cycle after its pop; o_empty=1 after the last.
- DEPTH=3 (non-power-of-2), FWFT=1: 10 interleaved push/pop of incrementing values -> in-order output across 3 pointer wraps; o_count never exceeds 3.
- Full, DEPTH=4, simultaneous push 0x55 + pop -> head popped; count stays 4; 0x55 is read 4th; o_overflow=0. Push alone while full -> o_overflow=1, sticky until i_clr_err.
- Empty, simultaneous push 0x7 + pop -> o_underflow=1, o_count=1, next read returns 0x7.
- i_afull_th=3: count rising 2->3 -> o_afull=1. With i_afull_th=0 -> o_afull=1 constant. With i_afull_th=5, DEPTH=4 -> o_afull=0 even when full.
- Count=3, assert i_flush together with push -> next cycle o_count=0, o_empty=1, no error flags. Then async i_rstn pulse mid-stream -> all outputs return to reset values immediately.
